inst_fetch: RTL and testbench

Instruction fetch stage of the 8-bit pipeline: owns the program counter, issues reads to instruction memory, and delivers instructions to the decode stage over a valid/ready handshake. A 2-entry buffer absorbs the one-cycle memory latency so decode can stall without losing fetched data. Branch/jump redirects from later stages flush the buffer and restart fetch at the new target.

---
 rtl/inst_fetch_pkg.sv | 25 ++
 rtl/inst_fetch_if.sv | 36 +++
 rtl/inst_fetch_buffer.sv | 68 ++++++
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the fetch stage (also used by inst_decode):
//   ADDR_WIDTH_DEF / INST_WIDTH_DEF : default address / instruction widths
//   RESET_PC_DEF                    : default PC loaded by reset
//   OPC_MSB / OPC_LSB               : opcode field position inside an instruction
//   OP_HALT                         : opcode that stops fetch when
//                                     INST_FETCH_HALT_EN is defined
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int INST_WIDTH_DEF = 8;
   localparam int RESET_PC_DEF   = 0;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;

   localparam logic [OPC_MSB-OPC_LSB:0] OP_HALT = 4'hF;

   function automatic logic is_halt(input logic [OPC_MSB-OPC_LSB:0] opc);
      return opc == OP_HALT;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Bundles the fetch stage's instruction-memory port, redirect input and
// decode-side valid/ready handshake.
//   master : the fetch stage (drives imem_rd_en/imem_addr, inst/inst_pc/
//            inst_valid, halted; receives imem_rdata, redirect/redirect_pc,
//            inst_ready)
//   slave  : the environment (memory, later stages, decode)
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
   parameter int ADDR_WIDTH = inst_fetch_pkg::ADDR_WIDTH_DEF,
   parameter int INST_WIDTH = inst_fetch_pkg::INST_WIDTH_DEF
);

   logic                  imem_rd_en;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [INST_WIDTH-1:0] imem_rdata;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [INST_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  inst_valid;
   logic                  inst_ready;
   logic                  halted;

   modport master (
      output imem_rd_en, imem_addr, inst, inst_pc, inst_valid, halted,
      input  imem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_rd_en, imem_addr, inst, inst_pc, inst_valid, halted,
      output imem_rdata, redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry synchronous FIFO of {inst, pc} pairs between instruction memory
// and decode. Simultaneous push and pop are allowed; flush empties it.
//   clk, rst        : clock, synchronous active-low reset
//   push_i          : write {push_inst_i, push_pc_i} at the tail
//   pop_i           : drop the head entry
//   flush_i         : discard all entries (wins over push/pop)
//   head_inst_o/pc_o: head entry (meaningful only while count_o != 0)
//   count_o         : number of stored entries, 0..2
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int ADDR_WIDTH = inst_fetch_pkg::ADDR_WIDTH_DEF,
   parameter int INST_WIDTH = inst_fetch_pkg::INST_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic [INST_WIDTH-1:0] push_inst_i,
   input  logic [ADDR_WIDTH-1:0] push_pc_i,
   output logic [INST_WIDTH-1:0] head_inst_o,
   output logic [ADDR_WIDTH-1:0] head_pc_o,
   output logic [1:0]            count_o
);

   logic [INST_WIDTH-1:0] inst_q [2];
   logic [ADDR_WIDTH-1:0] pc_q   [2];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            count_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the storage is reset (only two entries) so that inst/inst_pc
         // read as zero out of reset; larger memories would not be reset.
         inst_q[0] <= '0;
         inst_q[1] <= '0;
         pc_q[0]   <= '0;
         pc_q[1]   <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            inst_q[wr_ptr_q] <= push_inst_i;
            pc_q[wr_ptr_q]   <= push_pc_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign head_inst_o = inst_q[rd_ptr_q];
   assign head_pc_o   = pc_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage: owns the PC, issues single-cycle-latency reads to
// instruction memory and hands instructions to decode through fetch_buffer.
//   clk, rst : clock, synchronous active-low reset (0 = reset)
//   bus      : inst_fetch_if.master
//                imem_rd_en/imem_addr/imem_rdata : instruction memory port
//                redirect/redirect_pc            : flush and restart fetch
//                inst/inst_pc/inst_valid/inst_ready : decode handshake
//                halted                          : fetch stopped on HALT
// Build option: INST_FETCH_HALT_EN - opcode OP_HALT stops further reads once
// it lands in the buffer; halted rises the cycle after it is popped. Without
// the macro OP_HALT is an ordinary instruction and halted is tied low.
// -----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                    INST_WIDTH = INST_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
   input  logic        clk,
   input  logic        rst,
   inst_fetch_if.master bus
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic                  inflight_q;
   logic [ADDR_WIDTH-1:0] inflight_pc_q;

   logic [INST_WIDTH-1:0] head_inst;
   logic [ADDR_WIDTH-1:0] head_pc;
   logic [1:0]            count;
   logic [2:0]            occupancy;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic                  halt_hit;
   logic                  halt_pend;

   assign pop  = (count != 2'd0) & bus.inst_ready;
   // A redirect discards the response of the read issued last cycle.
   assign push = inflight_q & ~bus.redirect;

   // Entries that will be buffered or in flight after this edge, not counting
   // the read about to be issued; pop implies count >= 1, so no underflow.
   assign occupancy = 3'(count) + 3'(inflight_q) - 3'(pop);

   // halt_hit also blocks the read in the same cycle the HALT lands, so no
   // instruction past the HALT is ever fetched.
   assign issue = rst & ~bus.redirect & ~halt_pend & ~halt_hit & (occupancy < 3'd2);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
      end else if (bus.redirect) begin
         pc_q       <= bus.redirect_pc;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q          <= pc_q + ADDR_WIDTH'(1);
            inflight_pc_q <= pc_q;
         end
      end
   end

   fetch_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_fetch_buffer (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (bus.redirect),
      .push_inst_i (bus.imem_rdata),
      .push_pc_i   (inflight_pc_q),
      .head_inst_o (head_inst),
      .head_pc_o   (head_pc),
      .count_o     (count)
   );

`ifdef INST_FETCH_HALT_EN
   logic halt_pend_q;
   logic halted_q;
   logic halt_pop;

   assign halt_hit = push & is_halt(bus.imem_rdata[OPC_MSB:OPC_LSB]);
   // While halt_pend is set the only OP_HALT entry left is the one that set it.
   assign halt_pop = pop & halt_pend_q & is_halt(head_inst[OPC_MSB:OPC_LSB]);

   always_ff @(posedge clk) begin
      if (!rst || bus.redirect) begin
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         if (halt_hit) halt_pend_q <= 1'b1;
         if (halt_pop) halted_q    <= 1'b1;
      end
   end

   assign halt_pend  = halt_pend_q;
   assign bus.halted = halted_q;
`else
   assign halt_hit   = 1'b0;
   assign halt_pend  = 1'b0;
   assign bus.halted = 1'b0;
`endif

   assign bus.imem_rd_en = issue;
   assign bus.imem_addr  = pc_q;
   assign bus.inst       = head_inst;
   assign bus.inst_pc    = head_pc;
   assign bus.inst_valid = (count != 2'd0);

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Drives inst_fetch with directed and $urandom stimulus and compares every
// cycle against a queue-based reference model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam int AW = 8;
   localparam int IW = 8;
`ifdef INST_FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   inst_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

   inst_fetch #(
      .ADDR_WIDTH (AW),
      .INST_WIDTH (IW),
      .RESET_PC   (8'h00)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instruction memory contents and the responder's pending read.
   logic [7:0] mem [256];
   bit         resp_pend;
   logic [7:0] resp_addr;

   // Reference model: buffer as a queue of {inst, pc}, plus PC and one
   // outstanding read.
   logic [15:0] mq [$];
   logic [7:0]  m_pc;
   logic [7:0]  m_infl_pc;
   bit          m_infl;
   bit          m_halt_pend;
   bit          m_halted;

   // Inputs applied in the current cycle.
   logic       cur_rst;
   logic       cur_rdy;
   logic       cur_redir;
   logic [7:0] cur_rpc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_pop();
      return (mq.size() != 0) && (cur_rdy == 1'b1);
   endfunction

   function automatic bit model_rd_en();
      int occ;
      bit hit;
      occ = mq.size() + int'(m_infl) - int'(model_pop());
      hit = HALT_EN && m_infl && (mem[m_infl_pc][7:4] == 4'hF);
      return cur_rst && !cur_redir && !m_halt_pend && !hit && (occ < 2);
   endfunction

   task automatic model_check();
      check("imem_rd_en", 32'(bus.imem_rd_en), 32'(model_rd_en()));
      check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      check("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("inst", 32'(bus.inst), 32'(mq[0][15:8]));
         check("inst_pc", 32'(bus.inst_pc), 32'(mq[0][7:0]));
      end
      check("halted", 32'(bus.halted), 32'(m_halted));
   endtask

   task automatic model_advance();
      bit rd;
      bit pop;
      logic [15:0] e;
      rd  = model_rd_en();
      pop = model_pop();
      if (!cur_rst) begin
         mq.delete();
         m_pc = 8'h00; m_infl = 0; m_halt_pend = 0; m_halted = 0;
      end else if (cur_redir) begin
         mq.delete();
         m_pc = cur_rpc; m_infl = 0; m_halt_pend = 0; m_halted = 0;
      end else begin
         if (pop) begin
            e = mq.pop_front();
            if (HALT_EN && m_halt_pend && e[15:12] == 4'hF) m_halted = 1;
         end
         if (m_infl) begin
            mq.push_back({mem[m_infl_pc], m_infl_pc});
            if (HALT_EN && mem[m_infl_pc][7:4] == 4'hF) m_halt_pend = 1;
         end
         m_infl = rd;
         if (rd) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 8'd1;
         end
      end
   endtask

   // One clock cycle: apply inputs just after the rising edge, compare on the
   // falling edge, then record the read request and advance the model.
   task automatic step(input logic rst_v, input logic rdy_v, input logic redir_v,
                       input logic [7:0] rpc_v, input bit do_check);
      @(posedge clk);
      #1;
      bus.imem_rdata  = resp_pend ? mem[resp_addr] : 8'h00;
      rst             = rst_v;
      bus.inst_ready  = rdy_v;
      bus.redirect    = redir_v;
      bus.redirect_pc = rpc_v;
      cur_rst = rst_v; cur_rdy = rdy_v; cur_redir = redir_v; cur_rpc = rpc_v;
      @(negedge clk);
      if (do_check) model_check();
      resp_pend = bus.imem_rd_en;
      resp_addr = bus.imem_addr;
      model_advance();
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] epc;

      rst = 1'b0;
      bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00; bus.imem_rdata = 8'h00;
      resp_pend = 0; resp_addr = 8'h00;
      m_pc = 8'h00; m_infl_pc = 8'h00; m_infl = 0; m_halt_pend = 0; m_halted = 0;
      for (int i = 0; i < 256; i++) begin
         if (i < 64) begin
            mem[i] = 8'(8'h10 + i);
         end else begin
            v = 8'($urandom);
            if (v[7:4] == 4'hF) v[7] = 1'b0;
            mem[i] = v;
         end
      end

      // Reset: first cycle has unknown pre-reset state.
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 1);
      check("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'h00);
      check("rst_inst", 32'(bus.inst), 32'h00);
      check("rst_inst_pc", 32'(bus.inst_pc), 32'h00);
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd0);

      // Release with decode stalled: latency R+2, then hold at pc 0x00.
      step(1, 0, 0, 8'h00, 1);
      check("R_rd_en", 32'(bus.imem_rd_en), 32'd1);
      check("R_valid", 32'(bus.inst_valid), 32'd0);
      step(1, 0, 0, 8'h00, 1);
      check("R1_valid", 32'(bus.inst_valid), 32'd0);
      step(1, 0, 0, 8'h00, 1);
      check("R2_valid", 32'(bus.inst_valid), 32'd1);
      check("R2_inst", 32'(bus.inst), 32'h10);
      check("R2_inst_pc", 32'(bus.inst_pc), 32'h00);
      repeat (4) begin
         step(1, 0, 0, 8'h00, 1);
         check("stall_hold_pc", 32'(bus.inst_pc), 32'h00);
         check("stall_no_read", 32'(bus.imem_rd_en), 32'd0);
      end
      for (int k = 0; k < 6; k++) begin
         step(1, 1, 0, 8'h00, 1);
         check("release_valid", 32'(bus.inst_valid), 32'd1);
         check("release_pc", 32'(bus.inst_pc), 32'(k));
      end

      // Fill the buffer, then redirect to 0x40.
      repeat (3) step(1, 0, 0, 8'h00, 1);
      step(1, 1'($urandom), 1, 8'h40, 1);
      step(1, 1, 0, 8'h00, 1);
      check("redir_valid", 32'(bus.inst_valid), 32'd0);
      check("redir_addr", 32'(bus.imem_addr), 32'h40);
      step(1, 1, 0, 8'h00, 1);
      step(1, 1, 0, 8'h00, 1);
      check("redir_first_valid", 32'(bus.inst_valid), 32'd1);
      check("redir_first_pc", 32'(bus.inst_pc), 32'h40);

      // PC wrap: 0xFE, 0xFF, 0x00, ... with no stall.
      step(1, 1, 1, 8'hFE, 1);
      repeat (3) step(1, 1, 0, 8'h00, 1);
      epc = 8'hFE;
      for (int k = 0; k < 5; k++) begin
         check("wrap_valid", 32'(bus.inst_valid), 32'd1);
         check("wrap_pc", 32'(bus.inst_pc), 32'(epc));
         epc = epc + 8'd1;
         step(1, 1, 0, 8'h00, 1);
      end

      // Random traffic: stalls, redirects, occasional reset.
      for (int c = 0; c < 600; c++) begin
         step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)), 1);
      end

      // One-cycle reset mid-stream.
      repeat (4) step(1, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      step(1, 1, 0, 8'h00, 1);
      check("midrst_rd_en", 32'(bus.imem_rd_en), 32'd1);
      check("midrst_addr", 32'(bus.imem_addr), 32'h00);
      check("midrst_valid", 32'(bus.inst_valid), 32'd0);
      check("midrst_inst", 32'(bus.inst), 32'h00);
      check("midrst_inst_pc", 32'(bus.inst_pc), 32'h00);
      check("midrst_halted", 32'(bus.halted), 32'd0);
      repeat (4) step(1, 1, 0, 8'h00, 1);

      // HALT opcode at pc 0x03.
      mem[3] = 8'hF0;
      step(1, 1, 1, 8'h00, 1);
      repeat (12) step(1, 1, 0, 8'h00, 1);
`ifdef INST_FETCH_HALT_EN
      check("halt_halted", 32'(bus.halted), 32'd1);
      check("halt_no_read", 32'(bus.imem_rd_en), 32'd0);
      check("halt_valid", 32'(bus.inst_valid), 32'd0);
      step(1, 1, 1, 8'h00, 1);
      step(1, 1, 0, 8'h00, 1);
      check("resume_halted", 32'(bus.halted), 32'd0);
      check("resume_rd_en", 32'(bus.imem_rd_en), 32'd1);
      check("resume_addr", 32'(bus.imem_addr), 32'h00);
`else
      check("nohalt_halted", 32'(bus.halted), 32'd0);
      check("nohalt_valid", 32'(bus.inst_valid), 32'd1);
`endif
      repeat (6) step(1, 1, 0, 8'h00, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
